// File: rtl/sda_axi_reg_pkg.sv
// Shared response codes and FSM encoding for the AXI4-Lite to register-bus bridge.
package sda_axi_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } bridgeState_e;

endpackage

// File: rtl/sda_reg_timeout_counter.sv
// Counts cycles spent waiting for regAck; expired is high in the last allowed waiting cycle.
module sda_reg_timeout_counter #(
    parameter int TimeoutCycles = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] count_r;

    // wait-cycle counter, restarted whenever a new request is issued
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + CntW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/sda_axi_lite_reg_bridge.sv
// AXI4-Lite slave issuing one register-bus transaction at a time, alternating reads and writes.
// Optional no-ack recovery with SLVERR is enabled by defining SDA_REG_BRIDGE_TIMEOUT_EN.
module sda_axi_lite_reg_bridge
    import sda_axi_reg_pkg::*;
#(
    parameter int RegAddrWidth  = 8,
    parameter int TimeoutCycles = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [RegAddrWidth-1:0] s_axi_awaddr,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [RegAddrWidth-1:0] s_axi_araddr,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    regReq,
    output logic                    regWriteEn,
    output logic [RegAddrWidth-1:0] regAddr,
    output logic [31:0]             regWData,
    output logic [3:0]              regWStrb,
    input  logic                    regAck,
    input  logic [31:0]             regRData
);

    localparam logic [RegAddrWidth-1:0] AlignMask = {{(RegAddrWidth-2){1'b1}}, 2'b00};

    bridgeState_e state_r, nextState_s;
    logic awFull_r, wFull_r, arFull_r, awReady_r, wReady_r, arReady_r;
    logic awFullNext_s, wFullNext_s, arFullNext_s, clearW_s, clearR_s;
    logic [RegAddrWidth-1:0] awAddr_r, arAddr_r, regAddr_r, regAddrNext_s;
    logic [31:0] wData_r, regWData_r, regWDataNext_s, rData_r, rDataNext_s;
    logic [3:0]  wStrb_r, regWStrb_r, regWStrbNext_s;
    logic regReq_r, regReqNext_s, regWriteEn_r, regWriteEnNext_s;
    logic bValid_r, bValidNext_s, rValid_r, rValidNext_s;
    logic lastWasWrite_r, lastWasWriteNext_s;
    logic awHs_s, wHs_s, arHs_s;

    assign awHs_s = s_axi_awvalid && awReady_r;
    assign wHs_s  = s_axi_wvalid && wReady_r;
    assign arHs_s = s_axi_arvalid && arReady_r;

`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
    logic [1:0] bResp_r, bRespNext_s, rResp_r, rRespNext_s;
    logic reqExpired_s;

    sda_reg_timeout_counter #(.TimeoutCycles(TimeoutCycles)) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clear   ((state_r == ST_IDLE) && (nextState_s == ST_REQ)),
        .enable  (state_r == ST_REQ),
        .expired (reqExpired_s)
    );

    assign s_axi_bresp = bResp_r;
    assign s_axi_rresp = rResp_r;
`else
    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;
`endif

    // holding-register occupancy: a grant's completion frees the slot, a handshake fills it
    always_comb begin
        awFullNext_s = awFull_r;
        wFullNext_s  = wFull_r;
        arFullNext_s = arFull_r;
        if (clearW_s) begin
            awFullNext_s = 1'b0;
            wFullNext_s  = 1'b0;
        end else begin
            awFullNext_s = awFull_r || awHs_s;
            wFullNext_s  = wFull_r || wHs_s;
        end
        if (clearR_s) begin
            arFullNext_s = 1'b0;
        end else begin
            arFullNext_s = arFull_r || arHs_s;
        end
    end

    // AW/W/AR holding registers and their registered readies
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awFull_r <= 1'b0; wFull_r <= 1'b0; arFull_r <= 1'b0;
            awReady_r <= 1'b0; wReady_r <= 1'b0; arReady_r <= 1'b0;
            awAddr_r <= '0; arAddr_r <= '0; wData_r <= 32'h0; wStrb_r <= 4'h0;
        end else begin
            awFull_r  <= awFullNext_s;
            wFull_r   <= wFullNext_s;
            arFull_r  <= arFullNext_s;
            awReady_r <= ~awFullNext_s;
            wReady_r  <= ~wFullNext_s;
            arReady_r <= ~arFullNext_s;
            if (awHs_s) awAddr_r <= s_axi_awaddr;
            if (arHs_s) arAddr_r <= s_axi_araddr;
            if (wHs_s) begin
                wData_r <= s_axi_wdata;
                wStrb_r <= s_axi_wstrb;
            end
        end
    end

    // transaction FSM: arbitrate, hold the request until ack, then present the response
    always_comb begin
        nextState_s        = state_r;
        regReqNext_s       = regReq_r;
        regWriteEnNext_s   = regWriteEn_r;
        regAddrNext_s      = regAddr_r;
        regWDataNext_s     = regWData_r;
        regWStrbNext_s     = regWStrb_r;
        bValidNext_s       = bValid_r;
        rValidNext_s       = rValid_r;
        rDataNext_s        = rData_r;
        lastWasWriteNext_s = lastWasWrite_r;
        clearW_s           = 1'b0;
        clearR_s           = 1'b0;
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
        bRespNext_s = bResp_r;
        rRespNext_s = rResp_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (awFull_r && wFull_r && (!arFull_r || !lastWasWrite_r)) begin
                    nextState_s      = ST_REQ;
                    regReqNext_s     = 1'b1;
                    regWriteEnNext_s = 1'b1;
                    regAddrNext_s    = awAddr_r & AlignMask;
                    regWDataNext_s   = wData_r;
                    regWStrbNext_s   = wStrb_r;
                end else if (arFull_r) begin
                    nextState_s      = ST_REQ;
                    regReqNext_s     = 1'b1;
                    regWriteEnNext_s = 1'b0;
                    regAddrNext_s    = arAddr_r & AlignMask;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (regAck) begin
                    nextState_s  = ST_RESP;
                    regReqNext_s = 1'b0;
                    clearW_s     = regWriteEn_r;
                    clearR_s     = ~regWriteEn_r;
                    bValidNext_s = regWriteEn_r;
                    rValidNext_s = ~regWriteEn_r;
                    if (!regWriteEn_r) rDataNext_s = regRData;
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
                    if (regWriteEn_r) bRespNext_s = RESP_OKAY;
                    else rRespNext_s = RESP_OKAY;
                end else if (reqExpired_s) begin
                    nextState_s  = ST_RESP;
                    regReqNext_s = 1'b0;
                    clearW_s     = regWriteEn_r;
                    clearR_s     = ~regWriteEn_r;
                    bValidNext_s = regWriteEn_r;
                    rValidNext_s = ~regWriteEn_r;
                    if (regWriteEn_r) begin
                        bRespNext_s = RESP_SLVERR;
                    end else begin
                        rRespNext_s = RESP_SLVERR;
                        rDataNext_s = 32'h0;
                    end
`endif
                end else begin
                    nextState_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (regWriteEn_r && s_axi_bready) begin
                    nextState_s        = ST_IDLE;
                    bValidNext_s       = 1'b0;
                    lastWasWriteNext_s = 1'b1;
                end else if (!regWriteEn_r && s_axi_rready) begin
                    nextState_s        = ST_IDLE;
                    rValidNext_s       = 1'b0;
                    lastWasWriteNext_s = 1'b0;
                end else begin
                    nextState_s = ST_RESP;
                end
            end
            default: begin
                nextState_s  = ST_IDLE;
                regReqNext_s = 1'b0;
                bValidNext_s = 1'b0;
                rValidNext_s = 1'b0;
            end
        endcase
    end

    // FSM state and registered register-bus / response outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            regReq_r <= 1'b0; regWriteEn_r <= 1'b0; regAddr_r <= '0;
            regWData_r <= 32'h0; regWStrb_r <= 4'h0;
            bValid_r <= 1'b0; rValid_r <= 1'b0; rData_r <= 32'h0;
            lastWasWrite_r <= 1'b0;
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
            bResp_r <= RESP_OKAY; rResp_r <= RESP_OKAY;
`endif
        end else begin
            state_r <= nextState_s;
            regReq_r <= regReqNext_s; regWriteEn_r <= regWriteEnNext_s;
            regAddr_r <= regAddrNext_s; regWData_r <= regWDataNext_s;
            regWStrb_r <= regWStrbNext_s;
            bValid_r <= bValidNext_s; rValid_r <= rValidNext_s; rData_r <= rDataNext_s;
            lastWasWrite_r <= lastWasWriteNext_s;
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
            bResp_r <= bRespNext_s; rResp_r <= rRespNext_s;
`endif
        end
    end

    assign s_axi_awready = awReady_r;
    assign s_axi_wready  = wReady_r;
    assign s_axi_arready = arReady_r;
    assign s_axi_bvalid  = bValid_r;
    assign s_axi_rvalid  = rValid_r;
    assign s_axi_rdata   = rData_r;
    assign regReq        = regReq_r;
    assign regWriteEn    = regWriteEn_r;
    assign regAddr       = regAddr_r;
    assign regWData      = regWData_r;
    assign regWStrb      = regWStrb_r;

endmodule

// File: tb/tb_sda_axi_lite_reg_bridge.sv
// Bench for sda_axi_lite_reg_bridge: AXI master tasks, a register-block stub and a memory reference model.
module tb_sda_axi_lite_reg_bridge;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic s_axi_bready = 1'b0, s_axi_rready = 1'b0;
    logic [7:0] s_axi_awaddr = 8'h0, s_axi_araddr = 8'h0;
    logic [31:0] s_axi_wdata = 32'h0;
    logic [3:0] s_axi_wstrb = 4'h0;
    logic s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
    logic [1:0] s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic regReq, regWriteEn, regAck;
    logic [7:0] regAddr;
    logic [31:0] regWData, regRData;
    logic [3:0] regWStrb;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    req_t reqLog[$];
    logic [31:0] refMem[64];
    logic [31:0] stubMem[64];
    int ackDelay = 2;
    logic forceAck = 1'b0;
    int lowGap = 100;
    int minLowGap = 100;

    always #5 clk = ~clk;

    sda_axi_lite_reg_bridge #(.RegAddrWidth(8), .TimeoutCycles(TO)) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .regReq(regReq), .regWriteEn(regWriteEn), .regAddr(regAddr), .regWData(regWData),
        .regWStrb(regWStrb), .regAck(regAck), .regRData(regRData)
    );

    function automatic logic [31:0] mergeStrb(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Register-block stub: acks addresses below 0x80 ackDelay cycles after regReq rises.
    initial begin
        int age;
        logic prevReq;
        req_t cur;
        age = 0; prevReq = 1'b0; regAck = 1'b0; regRData = 32'h0; cur = '0;
        forever begin
            @(negedge clk);
            regAck = 1'b0;
            regRData = 32'h0;
            if (regReq === 1'b1) begin
                if (prevReq !== 1'b1) begin
                    cur = '{we: regWriteEn, addr: regAddr, wdata: regWData, strb: regWStrb};
                    reqLog.push_back(cur);
                    if (lowGap < minLowGap) minLowGap = lowGap;
                    age = 0;
                end else begin
                    checks++;
                    if (regWriteEn !== cur.we || regAddr !== cur.addr ||
                        (cur.we && (regWData !== cur.wdata || regWStrb !== cur.strb))) begin
                        errors++;
                        $display("FAIL reg_stable: we=%b addr=%h wd=%h st=%h required we=%b addr=%h wd=%h st=%h",
                                 regWriteEn, regAddr, regWData, regWStrb, cur.we, cur.addr, cur.wdata, cur.strb);
                    end
                end
                if (regAddr < 8'h80 && age == ackDelay) begin
                    regAck = 1'b1;
                    if (regWriteEn) stubMem[regAddr[7:2]] = mergeStrb(stubMem[regAddr[7:2]], regWData, regWStrb);
                    else regRData = stubMem[regAddr[7:2]];
                end
                age++;
                lowGap = 0;
            end else begin
                lowGap++;
            end
            if (forceAck) begin
                regAck = 1'b1;
                regRData = 32'hDEADBEEF;
            end
            prevReq = regReq;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic present(input bit doAw, input bit doW, input bit doAr, input logic [7:0] awA,
                           input logic [31:0] wD, input logic [3:0] wS, input logic [7:0] arA,
                           input string name);
        bit awDone, wDone, arDone, awHs, wHs, arHs;
        int n;
        awDone = !doAw; wDone = !doW; arDone = !doAr;
        s_axi_awaddr = awA; s_axi_wdata = wD; s_axi_wstrb = wS; s_axi_araddr = arA;
        s_axi_awvalid = doAw; s_axi_wvalid = doW; s_axi_arvalid = doAr;
        n = 0;
        while (!(awDone && wDone && arDone) && n < 100) begin
            awHs = s_axi_awvalid && s_axi_awready;
            wHs  = s_axi_wvalid && s_axi_wready;
            arHs = s_axi_arvalid && s_axi_arready;
            @(negedge clk);
            n++;
            if (awHs) begin s_axi_awvalid = 1'b0; awDone = 1'b1; end
            if (wHs)  begin s_axi_wvalid = 1'b0;  wDone = 1'b1;  end
            if (arHs) begin s_axi_arvalid = 1'b0; arDone = 1'b1; end
        end
        checks++;
        if (!(awDone && wDone && arDone)) begin
            errors++;
            $display("FAIL %s handshake: done aw=%0d w=%0d ar=%0d required all 1", name, awDone, wDone, arDone);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        end
    endtask

    task automatic collectB(input int rdyDelay, input string name, output logic [1:0] resp);
        int n;
        n = 0;
        while (s_axi_bvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (s_axi_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s bvalid timeout: bvalid=%b required 1", name, s_axi_bvalid);
            resp = 2'bxx;
            return;
        end
        resp = s_axi_bresp;
        for (int i = 0; i < rdyDelay; i++) begin
            @(negedge clk);
            checks++;
            if ({s_axi_bvalid, s_axi_bresp, regReq} !== {1'b1, resp, 1'b0}) begin
                errors++;
                $display("FAIL %s b_stall: bvalid=%b bresp=%b regReq=%b required 1 %b 0",
                         name, s_axi_bvalid, s_axi_bresp, regReq, resp);
            end
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic collectR(input int rdyDelay, input string name, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        n = 0;
        while (s_axi_rvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (s_axi_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s rvalid timeout: rvalid=%b required 1", name, s_axi_rvalid);
            data = 32'hxxxxxxxx;
            resp = 2'bxx;
            return;
        end
        data = s_axi_rdata;
        resp = s_axi_rresp;
        for (int i = 0; i < rdyDelay; i++) begin
            @(negedge clk);
            checks++;
            if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp, regReq} !== {1'b1, data, resp, 1'b0}) begin
                errors++;
                $display("FAIL %s r_stall: rvalid=%b rdata=%h rresp=%b regReq=%b required 1 %h %b 0",
                         name, s_axi_rvalid, s_axi_rdata, s_axi_rresp, regReq, data, resp);
            end
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, s_axi_bresp,
             s_axi_rresp, s_axi_rdata, regReq, regWriteEn, regAddr, regWData, regWStrb} !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b%b%b bv=%b rv=%b rdata=%h req=%b addr=%h required all 0",
                     s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                     s_axi_rdata, regReq, regAddr);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: readies=%b required 111",
                     {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] resp;
        logic [31:0] data, d0, d1;
        d0 = $urandom;
        reqLog.delete();
        present(1'b1, 1'b1, 1'b1, 8'h10, d0, 4'hF, 8'h10, "arb_first");
        refMem[4] = mergeStrb(refMem[4], d0, 4'hF);
        collectB(0, "arb_first_w", resp);
        collectR(0, "arb_first_r", data, resp);
        checks++;
        if (reqLog.size() != 2 || reqLog[0].we !== 1'b1 || reqLog[1].we !== 1'b0) begin
            errors++;
            $display("FAIL arb_write_first: count=%0d we0=%b we1=%b required 2 1 0",
                     reqLog.size(), reqLog[0].we, reqLog[1].we);
        end
        checks++;
        if (data !== refMem[4]) begin
            errors++;
            $display("FAIL arb_read_after_write: rdata=%h required %h", data, refMem[4]);
        end
        d0 = $urandom; d1 = $urandom;
        reqLog.delete();
        present(1'b1, 1'b1, 1'b0, 8'h14, d0, 4'hF, 8'h00, "alt_w1");
        refMem[5] = mergeStrb(refMem[5], d0, 4'hF);
        present(1'b1, 1'b1, 1'b1, 8'h18, d1, 4'hF, 8'h14, "alt_w2_r");
        refMem[6] = mergeStrb(refMem[6], d1, 4'hF);
        collectB(2, "alt_w1", resp);
        collectR(0, "alt_r", data, resp);
        collectB(0, "alt_w2", resp);
        checks++;
        if (reqLog.size() != 3 || reqLog[0].we !== 1'b1 || reqLog[1].we !== 1'b0 ||
            reqLog[2].we !== 1'b1 || reqLog[2].addr !== 8'h18) begin
            errors++;
            $display("FAIL arb_alternate: count=%0d we=%b%b%b addr2=%h required 3 101 18", reqLog.size(),
                     reqLog[0].we, reqLog[1].we, reqLog[2].we, reqLog[2].addr);
        end
        checks++;
        if (data !== refMem[5]) begin
            errors++;
            $display("FAIL arb_alt_rdata: rdata=%h required %h", data, refMem[5]);
        end
    endtask

    task automatic test_write_aw_first();
        logic [1:0] resp;
        reqLog.delete();
        ackDelay = 2;
        present(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 8'h00, "wr_aw");
        repeat (3) @(negedge clk);
        present(1'b0, 1'b1, 1'b0, 8'h00, 32'h1, 4'hF, 8'h00, "wr_w");
        refMem[0] = 32'h1;
        collectB(0, "wr_aw_first", resp);
        checks++;
        if (resp !== 2'b00) begin
            errors++;
            $display("FAIL wr_bresp: bresp=%b required 00", resp);
        end
        checks++;
        if (reqLog.size() != 1 || reqLog[0] !== req_t'{we: 1'b1, addr: 8'h00, wdata: 32'h1, strb: 4'hF}) begin
            errors++;
            $display("FAIL wr_reg_fields: count=%0d fields=%h required 1 %h", reqLog.size(), reqLog[0],
                     req_t'{we: 1'b1, addr: 8'h00, wdata: 32'h1, strb: 4'hF});
        end
    endtask

    task automatic test_read_basic();
        logic [1:0] resp;
        logic [31:0] data;
        stubMem[3] = 32'h3;
        refMem[3] = 32'h3;
        ackDelay = 2;
        reqLog.delete();
        present(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, 8'h0C, "rd_basic");
        collectR(0, "rd_basic", data, resp);
        checks++;
        if (data !== 32'h3 || resp !== 2'b00 || reqLog[0].addr !== 8'h0C || reqLog[0].we !== 1'b0) begin
            errors++;
            $display("FAIL rd_basic: rdata=%h rresp=%b addr=%h we=%b required 3 00 0c 0",
                     data, resp, reqLog[0].addr, reqLog[0].we);
        end
    endtask

    task automatic test_align_stall();
        logic [1:0] resp;
        logic [31:0] data;
        reqLog.delete();
        ackDelay = 1;
        present(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, 8'h0E, "align_rd");
        present(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, 8'h22, "align_queued");
        collectR(5, "align_stall", data, resp);
        checks++;
        if (data !== refMem[3] || reqLog[0].addr !== 8'h0C || reqLog.size() != 1) begin
            errors++;
            $display("FAIL align_rd: rdata=%h addr=%h count=%0d required %h 0c 1",
                     data, reqLog[0].addr, reqLog.size(), refMem[3]);
        end
        collectR(0, "align_second", data, resp);
        checks++;
        if (data !== refMem[8] || reqLog.size() != 2 || reqLog[1].addr !== 8'h20) begin
            errors++;
            $display("FAIL align_second: rdata=%h count=%0d addr=%h required %h 2 20",
                     data, reqLog.size(), reqLog[1].addr, refMem[8]);
        end
    endtask

    task automatic test_ack_outside_req();
        forceAck = 1'b1;
        @(negedge clk);
        forceAck = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({s_axi_bvalid, s_axi_rvalid, regReq} !== 3'b000) begin
            errors++;
            $display("FAIL stray_ack: bvalid=%b rvalid=%b regReq=%b required 000",
                     s_axi_bvalid, s_axi_rvalid, regReq);
        end
    endtask

    task automatic test_unacked_reset();
        logic [1:0] resp;
        logic [31:0] data;
        int n, reqCycles;
        reqLog.delete();
        present(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, 8'h80, "noack_rd");
`ifdef SDA_REG_BRIDGE_TIMEOUT_EN
        n = 0; reqCycles = 0;
        while (s_axi_rvalid !== 1'b1 && n < 100) begin
            if (regReq === 1'b1) reqCycles++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (reqCycles != TO || s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b10 || s_axi_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp: reqCycles=%0d rvalid=%b rresp=%b rdata=%h required %0d 1 10 0",
                     reqCycles, s_axi_rvalid, s_axi_rresp, s_axi_rdata, TO);
        end
        forceAck = 1'b1;
        @(negedge clk);
        forceAck = 1'b0;
        collectR(2, "timeout_late_ack", data, resp);
        checks++;
        if (data !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL timeout_late_ack: rdata=%h rresp=%b required 0 10", data, resp);
        end
        present(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, 8'h80, "noack_rd2");
        repeat (3) @(negedge clk);
`else
        n = 0; reqCycles = 0;
        repeat (40) @(negedge clk);
        checks++;
        if (regReq !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL noack_wait: regReq=%b rvalid=%b required 1 0", regReq, s_axi_rvalid);
        end
`endif
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({regReq, s_axi_rvalid, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b rv=%b bv=%b rdy=%b%b%b required all 0", regReq,
                     s_axi_rvalid, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({regReq, s_axi_rvalid, s_axi_bvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_discard: regReq=%b rvalid=%b bvalid=%b required 000",
                     regReq, s_axi_rvalid, s_axi_bvalid);
        end
        data = $urandom;
        ackDelay = 2;
        present(1'b1, 1'b1, 1'b0, 8'h04, data, 4'hF, 8'h00, "post_reset_w");
        refMem[1] = data;
        collectB(0, "post_reset_w", resp);
        present(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, 8'h04, "post_reset_r");
        collectR(0, "post_reset_r", data, resp);
        checks++;
        if (data !== refMem[1] || resp !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_rd: rdata=%h rresp=%b required %h 00", data, resp, refMem[1]);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp;
        logic [31:0] data, wd;
        logic [7:0] addr;
        logic [3:0] st;
        int mode;
        for (int t = 0; t < 40; t++) begin
            ackDelay = $urandom_range(0, 4);
            addr = 8'($urandom_range(0, 127));
            reqLog.delete();
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                st = 4'($urandom_range(0, 15));
                mode = $urandom_range(0, 2);
                if (mode == 0) begin
                    present(1'b1, 1'b1, 1'b0, addr, wd, st, 8'h00, "rnd_w");
                end else if (mode == 1) begin
                    present(1'b1, 1'b0, 1'b0, addr, wd, st, 8'h00, "rnd_aw");
                    present(1'b0, 1'b1, 1'b0, addr, wd, st, 8'h00, "rnd_w");
                end else begin
                    present(1'b0, 1'b1, 1'b0, addr, wd, st, 8'h00, "rnd_w");
                    present(1'b1, 1'b0, 1'b0, addr, wd, st, 8'h00, "rnd_aw");
                end
                refMem[addr[7:2]] = mergeStrb(refMem[addr[7:2]], wd, st);
                collectB($urandom_range(0, 3), "rnd_w", resp);
                checks++;
                if (resp !== 2'b00 || reqLog.size() != 1 ||
                    reqLog[0] !== req_t'{we: 1'b1, addr: {addr[7:2], 2'b00}, wdata: wd, strb: st}) begin
                    errors++;
                    $display("FAIL rnd_write %0d: bresp=%b count=%0d fields=%h required 00 1 %h", t, resp,
                             reqLog.size(), reqLog[0], req_t'{we: 1'b1, addr: {addr[7:2], 2'b00}, wdata: wd, strb: st});
                end
            end else begin
                present(1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 4'h0, addr, "rnd_r");
                collectR($urandom_range(0, 3), "rnd_r", data, resp);
                checks++;
                if (data !== refMem[addr[7:2]] || resp !== 2'b00 || reqLog.size() != 1 ||
                    reqLog[0].addr !== {addr[7:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rnd_read %0d: rdata=%h rresp=%b count=%0d addr=%h required %h 00 1 %h", t,
                             data, resp, reqLog.size(), reqLog[0].addr, refMem[addr[7:2]], {addr[7:2], 2'b00});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (minLowGap < 2) begin
            errors++;
            $display("FAIL req_low_gap: min low cycles=%0d required >= 2", minLowGap);
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            refMem[i] = v;
            stubMem[i] = v;
        end
        test_reset();
        test_arbitration();
        test_write_aw_first();
        test_read_basic();
        test_align_stall();
        test_ack_outside_req();
        test_unacked_reset();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
